// File: rtl/hmm_pkg.sv
// Shared constants and FSM state encoding for the HMM frame driver and its feature buffer.
package hmm_pkg;

  localparam int DIM_DEF   = 12;
  localparam int STATE_DEF = 12;
  localparam int SCORE_W   = 64;

  typedef enum logic [1:0] {
    FILL,
    SEND,
    WAIT,
    REST
  } state_e;

endpackage

// File: rtl/hmm_feat_buf.sv
// Feature frame register file: NBANK banks of DIM words, one write port, one read port,
// and a full flag for the bank addressed by the write port.
module hmm_feat_buf #(
  parameter int W     = 32,
  parameter int DIM   = 12,
  parameter int NBANK = 1,
  parameter int IW    = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_bank,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  input  logic          clr_en,
  input  logic          clr_bank,
  output logic          full_o
);

  localparam int AW = $clog2(NBANK * DIM);

  logic [W-1:0]     mem_q [NBANK*DIM];
  logic [NBANK-1:0] full_q;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  assign wr_addr = AW'(int'(wr_bank) * DIM + int'(wr_idx));
  assign rd_addr = AW'(int'(rd_bank) * DIM + int'(rd_idx));
  assign rd_data = mem_q[rd_addr];

  // NOTE: storage is deliberately left out of reset; only the full flags need a known value.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Clearing wins over setting: a bank handed to the engine on its last write reads as empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (clr_en && clr_bank == 1'(b))
          full_q[b] <= 1'b0;
        else if (wr_en && wr_bank == 1'(b) && wr_idx == IW'(DIM - 1))
          full_q[b] <= 1'b1;
      end
    end
  end

  always_comb begin
    full_o = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      if (wr_bank == 1'(b)) full_o = full_q[b];
    end
  end

endmodule

// File: rtl/hmm_frame_driver.sv
// Initiator for the HMM scoring engine: buffers a feature frame, loads it, and reports the argmax state.
// Define HMM_DRV_PINGPONG_EN for two feature banks so the next frame fills while the current one is scored.
module hmm_frame_driver
  import hmm_pkg::*;
#(
  parameter int BWIDTH = 16,
  parameter int DIM    = DIM_DEF,
  parameter int STATE  = STATE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        feat_valid,
  input  logic signed [2*BWIDTH-1:0]  feat_data,
  output logic                        feat_ready,
  output logic                        hmm_start,
  output logic signed [2*BWIDTH-1:0]  hmm_x,
  input  logic                        hmm_load,
  input  logic                        hmm_dv,
  input  logic [15:0]                 hmm_index,
  input  logic signed [SCORE_W-1:0]   hmm_score,
  input  logic                        hmm_done,
  output logic                        res_valid,
  output logic [15:0]                 res_state,
  output logic signed [SCORE_W-1:0]   res_score,
  output logic                        res_err,
  output logic [15:0]                 frame_cnt
);

  localparam int W  = 2 * BWIDTH;
  localparam int IW = $clog2(DIM);
`ifdef HMM_DRV_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  state_e                     state_q, state_d;
  logic [IW-1:0]              wr_idx_q, wr_idx_d;
  logic [IW-1:0]              send_k_q, send_k_d;
  logic                       fill_bank_q, fill_bank_d;
  logic                       send_bank_q, send_bank_d;
  logic [15:0]                dv_cnt_q, dv_cnt_d;
  logic                       err_q, err_d;
  logic                       has_best_q, has_best_d;
  logic signed [SCORE_W-1:0]  best_q, best_d;
  logic [15:0]                best_idx_q, best_idx_d;
  logic                       feat_ready_q, feat_ready_d;
  logic                       hmm_start_q, hmm_start_d;
  logic signed [W-1:0]        hmm_x_q, hmm_x_d;
  logic                       res_valid_q, res_valid_d;
  logic [15:0]                res_state_q, res_state_d;
  logic signed [SCORE_W-1:0]  res_score_q, res_score_d;
  logic                       res_err_q, res_err_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;

  logic          wr_fire, last_wr, handoff, clr_en, fill_full, rd_bank;
  logic [IW-1:0] rd_idx;
  logic [W-1:0]  rd_data;

  assign wr_fire = feat_valid && feat_ready_q;
  assign last_wr = wr_fire && (wr_idx_q == IW'(DIM - 1));

  // Address one word ahead so hmm_x is registered in step with the SEND counter.
  assign rd_idx  = (state_q == SEND && send_k_q != IW'(DIM - 1)) ? send_k_q + 1'b1 : '0;
  assign rd_bank = (state_q == SEND) ? send_bank_q : fill_bank_q;

  hmm_feat_buf #(
    .W     (W),
    .DIM   (DIM),
    .NBANK (NBANK),
    .IW    (IW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_fire),
    .wr_bank  (fill_bank_q),
    .wr_idx   (wr_idx_q),
    .wr_data  (feat_data),
    .rd_bank  (rd_bank),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .clr_en   (clr_en),
    .clr_bank (fill_bank_q),
    .full_o   (fill_full)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    send_k_d    = send_k_q;
    fill_bank_d = fill_bank_q;
    send_bank_d = send_bank_q;
    dv_cnt_d    = dv_cnt_q;
    err_d       = err_q;
    has_best_d  = has_best_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    res_valid_d = 1'b0;
    res_state_d = res_state_q;
    res_score_d = res_score_q;
    res_err_d   = res_err_q;
    frame_cnt_d = frame_cnt_q;
    handoff     = 1'b0;
    clr_en      = 1'b0;

    if (wr_fire) wr_idx_d = last_wr ? '0 : wr_idx_q + 1'b1;

    unique case (state_q)
      FILL: begin
        if (last_wr) handoff = 1'b1;
      end
      SEND: begin
        if ((send_k_q != '0 && !hmm_load) || hmm_done) err_d = 1'b1;
        if (send_k_q == IW'(DIM - 1)) state_d = WAIT;
        else                          send_k_d = send_k_q + 1'b1;
      end
      WAIT: begin
        if (hmm_dv) begin
          dv_cnt_d = (dv_cnt_q == '1) ? dv_cnt_q : dv_cnt_q + 1'b1;
          if (hmm_index >= 16'(STATE)) begin
            err_d = 1'b1;
          end else if (!has_best_q || hmm_score > best_q) begin
            has_best_d = 1'b1;
            best_d     = hmm_score;
            best_idx_d = hmm_index;
          end
        end
        // The result is formed from the dv-updated values so a coincident dv is counted.
        if (hmm_done) begin
          res_valid_d = 1'b1;
          res_state_d = best_idx_d;
          res_score_d = best_d;
          res_err_d   = err_d | (dv_cnt_d != 16'(STATE));
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = REST;
        end
      end
      REST: begin
        dv_cnt_d   = '0;
        err_d      = 1'b0;
        has_best_d = 1'b0;
        best_d     = '0;
        best_idx_d = '0;
        state_d    = FILL;
        if (fill_full || last_wr) handoff = 1'b1;
      end
      default: state_d = FILL;
    endcase

    if (handoff) begin
      state_d     = SEND;
      send_k_d    = '0;
      send_bank_d = fill_bank_q;
      clr_en      = 1'b1;
`ifdef HMM_DRV_PINGPONG_EN
      fill_bank_d = ~fill_bank_q;
`endif
    end

    hmm_start_d = (state_d == SEND) || (state_d == WAIT);
    hmm_x_d     = (state_d == SEND) ? rd_data : '0;
`ifdef HMM_DRV_PINGPONG_EN
    feat_ready_d = (state_d == FILL) || !(handoff ? 1'b0 : (fill_full || last_wr));
`else
    feat_ready_d = (state_d == FILL);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      wr_idx_q     <= '0;
      send_k_q     <= '0;
      fill_bank_q  <= 1'b0;
      send_bank_q  <= 1'b0;
      dv_cnt_q     <= '0;
      err_q        <= 1'b0;
      has_best_q   <= 1'b0;
      best_q       <= '0;
      best_idx_q   <= '0;
      feat_ready_q <= 1'b0;
      hmm_start_q  <= 1'b0;
      hmm_x_q      <= '0;
      res_valid_q  <= 1'b0;
      res_state_q  <= '0;
      res_score_q  <= '0;
      res_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      send_k_q     <= send_k_d;
      fill_bank_q  <= fill_bank_d;
      send_bank_q  <= send_bank_d;
      dv_cnt_q     <= dv_cnt_d;
      err_q        <= err_d;
      has_best_q   <= has_best_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      feat_ready_q <= feat_ready_d;
      hmm_start_q  <= hmm_start_d;
      hmm_x_q      <= hmm_x_d;
      res_valid_q  <= res_valid_d;
      res_state_q  <= res_state_d;
      res_score_q  <= res_score_d;
      res_err_q    <= res_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign feat_ready = feat_ready_q;
  assign hmm_start  = hmm_start_q;
  assign hmm_x      = hmm_x_q;
  assign res_valid  = res_valid_q;
  assign res_state  = res_state_q;
  assign res_score  = res_score_q;
  assign res_err    = res_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_hmm_frame_driver.sv
// Testbench for hmm_frame_driver: directed frames plus randomized score streams against a reference model.
module tb_hmm_frame_driver;

  localparam int BWIDTH = 16;
  localparam int W      = 2 * BWIDTH;
  localparam int DIM    = 12;
  localparam int STATE  = 12;
`ifdef HMM_DRV_PINGPONG_EN
  localparam int WAIT_READY = 1;
`else
  localparam int WAIT_READY = 0;
`endif

  typedef logic signed [W-1:0] frame_t [DIM];

  logic                clk = 1'b0;
  logic                reset;
  logic                feat_valid;
  logic signed [W-1:0] feat_data;
  logic                feat_ready;
  logic                hmm_start;
  logic signed [W-1:0] hmm_x;
  logic                hmm_load;
  logic                hmm_dv;
  logic [15:0]         hmm_index;
  logic signed [63:0]  hmm_score;
  logic                hmm_done;
  logic                res_valid;
  logic [15:0]         res_state;
  logic signed [63:0]  res_score;
  logic                res_err;
  logic [15:0]         frame_cnt;

  int n_pass = 0;
  int n_total = 0;
  int exp_frames = 0;
  logic [15:0]        q_idx[$];
  logic signed [63:0] q_sc[$];

  always #5 clk = ~clk;

  hmm_frame_driver #(.BWIDTH(BWIDTH), .DIM(DIM), .STATE(STATE)) dut (
    .clk        (clk),
    .reset      (reset),
    .feat_valid (feat_valid),
    .feat_data  (feat_data),
    .feat_ready (feat_ready),
    .hmm_start  (hmm_start),
    .hmm_x      (hmm_x),
    .hmm_load   (hmm_load),
    .hmm_dv     (hmm_dv),
    .hmm_index  (hmm_index),
    .hmm_score  (hmm_score),
    .hmm_done   (hmm_done),
    .res_valid  (res_valid),
    .res_state  (res_state),
    .res_score  (res_score),
    .res_err    (res_err),
    .frame_cnt  (frame_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: best = maximum score over in-range indices, earliest arrival among equals.
  function automatic void model(output logic [15:0] st, output logic signed [63:0] sc,
                                output bit err, output bit bad);
    logic signed [63:0] mx;
    bit any;
    any = 0; bad = 0; st = '0; sc = '0; mx = '0;
    foreach (q_sc[i]) begin
      if (q_idx[i] >= STATE) bad = 1;
      else if (!any || q_sc[i] > mx) begin mx = q_sc[i]; any = 1; end
    end
    if (any) begin
      sc = mx;
      for (int i = q_sc.size() - 1; i >= 0; i--)
        if (q_idx[i] < STATE && q_sc[i] == mx) st = q_idx[i];
    end
    err = bad || (q_sc.size() != STATE);
  endfunction

  task automatic fill_words(input frame_t w);
    int budget;
    for (int i = 0; i < DIM; i++) begin
      budget = 0;
      feat_valid = 1'b1;
      feat_data  = w[i];
      while (feat_ready !== 1'b1 && budget < 100) begin step(); budget++; end
      n_total++;
      if (budget >= 100) $display("FAIL fill_ready word %0d: feat_ready=%b want 1", i, feat_ready);
      else n_pass++;
      step();
    end
    feat_valid = 1'b0;
  endtask

  task automatic check_send(input frame_t w, input string tag);
    for (int k = 0; k < DIM; k++) begin
      if (k > 0) step();
      n_total++;
      if (hmm_start !== 1'b1 || hmm_x !== w[k])
        $display("FAIL %s send[%0d]: start=%b x=%h want start=1 x=%h", tag, k, hmm_start, hmm_x, w[k]);
      else n_pass++;
    end
    step();
    n_total++;
    if (hmm_start !== 1'b1 || hmm_x !== '0)
      $display("FAIL %s wait_entry: start=%b x=%h want start=1 x=0", tag, hmm_start, hmm_x);
    else n_pass++;
  endtask

  task automatic finish_frame(input bit done_with_last, input int wait_ready, input string tag);
    logic [15:0]        e_st;
    logic signed [63:0] e_sc;
    bit                 e_err, bad, last_done;
    model(e_st, e_sc, e_err, bad);
    foreach (q_idx[i]) begin
      last_done = done_with_last && (i == q_idx.size() - 1);
      hmm_dv = 1'b1; hmm_index = q_idx[i]; hmm_score = q_sc[i]; hmm_done = last_done;
      step();
      hmm_dv = 1'b0;
      if (!last_done) begin
        n_total++;
        if (res_valid !== 1'b0) $display("FAIL %s early_res dv%0d: res_valid=%b want 0", tag, i, res_valid);
        else n_pass++;
        if (wait_ready >= 0) begin
          n_total++;
          if (feat_ready !== 1'(wait_ready))
            $display("FAIL %s wait_ready dv%0d: feat_ready=%b want %0d", tag, i, feat_ready, wait_ready);
          else n_pass++;
        end
        repeat ($urandom_range(0, 1)) step();
      end
    end
    if (!done_with_last) begin hmm_done = 1'b1; step(); end
    n_total++;
    if (res_valid !== 1'b1 || res_err !== e_err || hmm_start !== 1'b0)
      $display("FAIL %s result: valid=%b err=%b start=%b want 1 %b 0", tag, res_valid, res_err, hmm_start, e_err);
    else n_pass++;
    if (!bad) begin
      n_total++;
      if (res_state !== e_st || res_score !== e_sc)
        $display("FAIL %s argmax: state=%0d score=%0d want %0d %0d", tag, res_state, res_score, e_st, e_sc);
      else n_pass++;
    end
    n_total++;
    if (frame_cnt !== 16'(exp_frames + 1))
      $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, exp_frames + 1);
    else n_pass++;
    exp_frames++;
    hmm_done = 1'b0;
    step();
    n_total++;
    if (res_valid !== 1'b0 || feat_ready !== 1'b1)
      $display("FAIL %s after_rest: valid=%b ready=%b want 0 1", tag, res_valid, feat_ready);
    else n_pass++;
  endtask

  task automatic rand_frame(output frame_t w);
    for (int i = 0; i < DIM; i++) w[i] = $signed($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_total++;
    if (feat_ready !== 1'b0 || hmm_start !== 1'b0 || hmm_x !== '0)
      $display("FAIL reset_drive: ready=%b start=%b x=%h want 0 0 0", feat_ready, hmm_start, hmm_x);
    else n_pass++;
    n_total++;
    if (res_valid !== 1'b0 || res_state !== '0 || res_score !== '0 || res_err !== 1'b0)
      $display("FAIL reset_result: v=%b st=%0d sc=%0d e=%b want zeros", res_valid, res_state, res_score, res_err);
    else n_pass++;
    n_total++;
    if (frame_cnt !== '0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    else n_pass++;
    reset = 1'b0;
    step();
    n_total++;
    if (feat_ready !== 1'b1 || hmm_start !== 1'b0)
      $display("FAIL reset_release: ready=%b start=%b want 1 0", feat_ready, hmm_start);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    frame_t w;
    rand_frame(w);
    fill_words(w);
    check_send(w, "mid_reset");
    for (int i = 0; i < 4; i++) begin
      hmm_dv = 1'b1; hmm_index = 16'(i); hmm_score = 64'(i);
      step();
    end
    hmm_dv = 1'b0;
    reset = 1'b1;
    step();
    n_total++;
    if (hmm_start !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL mid_reset_drop: start=%b valid=%b want 0 0", hmm_start, res_valid);
    else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if (feat_ready !== 1'b1 || res_valid !== 1'b0 || frame_cnt !== 16'(exp_frames))
        $display("FAIL mid_reset_idle c%0d: ready=%b valid=%b cnt=%0d want 1 0 %0d",
                 c, feat_ready, res_valid, frame_cnt, exp_frames);
      else n_pass++;
    end
  endtask

  task automatic test_single_frame();
    frame_t w;
    for (int i = 0; i < DIM; i++) w[i] = W'(i + 1);
    fill_words(w);
    check_send(w, "single");
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE; i++) begin
      q_idx.push_back(16'(i));
      q_sc.push_back((i == 5) ? -64'sd3 : 64'(-100 + (60 * i) / 11));
    end
    finish_frame(1'b0, WAIT_READY, "single");
  endtask

  task automatic test_tie();
    frame_t w;
    rand_frame(w);
    fill_words(w);
    check_send(w, "tie");
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE; i++) begin
      q_idx.push_back(16'(i));
      q_sc.push_back((i == 2 || i == 9) ? -64'sd7 : 64'(-50 - i));
    end
    finish_frame(1'b0, WAIT_READY, "tie");
  endtask

  task automatic test_short_stream();
    frame_t w;
    rand_frame(w);
    fill_words(w);
    check_send(w, "short");
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE - 1; i++) begin q_idx.push_back(16'(i)); q_sc.push_back(64'(i * 3)); end
    finish_frame(1'b0, WAIT_READY, "short");
    rand_frame(w);
    fill_words(w);
    check_send(w, "bad_idx");
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE; i++) begin
      q_idx.push_back((i == 7) ? 16'(STATE) : 16'(i));
      q_sc.push_back(64'(i));
    end
    finish_frame(1'b0, WAIT_READY, "bad_idx");
  endtask

`ifdef HMM_DRV_PINGPONG_EN
  task automatic test_back_to_back();
    frame_t w1, w2;
    rand_frame(w1); rand_frame(w2);
    fill_words(w1);
    check_send(w1, "b2b_f1");
    n_total++;
    if (feat_ready !== 1'b1) $display("FAIL b2b_ready_wait: got %b want 1", feat_ready);
    else n_pass++;
    fill_words(w2);
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE; i++) begin q_idx.push_back(16'(i)); q_sc.push_back(64'($urandom_range(0, 9))); end
    finish_frame(1'b0, 0, "b2b_f1");
    check_send(w2, "b2b_f2");
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE; i++) begin q_idx.push_back(16'(i)); q_sc.push_back(-64'(i)); end
    finish_frame(1'b1, 1, "b2b_f2");
  endtask
`else
  task automatic test_ready_gating();
    frame_t w1, w2;
    rand_frame(w1); rand_frame(w2);
    fill_words(w1);
    check_send(w1, "gate_f1");
    feat_valid = 1'b1;
    feat_data  = w2[0];
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE; i++) begin q_idx.push_back(16'(i)); q_sc.push_back(64'(i)); end
    finish_frame(1'b0, 0, "gate_f1");
    fill_words(w2);
    check_send(w2, "gate_f2");
    q_idx.delete(); q_sc.delete();
    for (int i = 0; i < STATE; i++) begin q_idx.push_back(16'(i)); q_sc.push_back(64'(20 - i)); end
    finish_frame(1'b1, 0, "gate_f2");
  endtask
`endif

  task automatic test_random();
    frame_t w;
    int n;
    for (int f = 0; f < 8; f++) begin
      rand_frame(w);
      fill_words(w);
      check_send(w, "rand");
      q_idx.delete(); q_sc.delete();
      n = $urandom_range(STATE - 1, STATE + 1);
      for (int i = 0; i < n; i++) begin
        q_idx.push_back(($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 15)) : 16'(i));
        if ($urandom_range(0, 3) == 0) q_sc.push_back($signed({$urandom, $urandom}));
        else q_sc.push_back(64'($urandom_range(0, 30)) - 64'sd15);
      end
      finish_frame(1'($urandom_range(0, 1)), WAIT_READY, "rand");
    end
  endtask

  initial begin
    reset = 1'b1; feat_valid = 1'b0; feat_data = '0; hmm_load = 1'b1;
    hmm_dv = 1'b0; hmm_index = '0; hmm_score = '0; hmm_done = 1'b0;
    test_reset();
    test_reset_mid_wait();
    test_single_frame();
    test_tie();
    test_short_stream();
`ifdef HMM_DRV_PINGPONG_EN
    test_back_to_back();
`else
    test_ready_gating();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
